// File: rtl/miriscv_timer_pkg.sv
// miriscv_timer_pkg
//   Shared constants for the memory-mapped compare timer: word offsets of the
//   registers inside the 32-byte window (addr[4:2]), CTRL/STATUS bit
//   positions, reset value of CMP and the byte-lane write merge helper.
package miriscv_timer_pkg;

  // Word offsets (addr[4:2]); 5..7 are unmapped
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_CNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // CTRL fields
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_W      = 3;

  // STATUS fields
  localparam int unsigned STATUS_PEND = 0;
  localparam int unsigned STATUS_EN   = 1;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  // Replace only the byte lanes whose enable is set
  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res[7:0]   = be[0] ? new_val[7:0]   : old_val[7:0];
    res[15:8]  = be[1] ? new_val[15:8]  : old_val[15:8];
    res[23:16] = be[2] ? new_val[23:16] : old_val[23:16];
    res[31:24] = be[3] ? new_val[31:24] : old_val[31:24];
    return res;
  endfunction

endpackage

// File: rtl/miriscv_timer_prescaler.sv
// timer_prescaler
//   Divides the clock into counter ticks. pcnt runs 0..presc_i while enabled;
//   tick_o is asserted in the cycle where pcnt equals presc_i, after which
//   pcnt restarts at 0. presc_i = 0 gives a tick every cycle.
// Ports
//   clk_i    in  clock
//   rst_n_i  in  asynchronous active-low reset
//   en_i     in  timer enable; low holds pcnt at 0
//   clr_i    in  restart the division (CTRL/PRESC bus write)
//   presc_i  in  division value
//   tick_o   out counter advance strobe (combinational from pcnt/en/presc)
module timer_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pcnt;

  assign tick_o = en_i && (pcnt == presc_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt <= '0;
    end else if (clr_i || !en_i || tick_o) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/miriscv_timer.sv
// miriscv_timer
//   Memory-mapped compare timer on the core data bus. A prescaled 32-bit
//   counter is compared against CMP; a match latches PEND and either reloads
//   the counter (AUTO_RELOAD) or stops the timer (one-shot). int_req_o is
//   PEND gated by IRQ_EN and is retired by int_fin_i or a STATUS W1C.
// Ports
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   req_i, we_i     decoded bus request, 1 = write
//   be_i            write byte enables
//   addr_i          byte address, word offset addr[4:2] inside the window
//   wdata_i         write data
//   rdata_o         combinational read data (0 when not reading)
//   int_req_o       level interrupt request
//   int_fin_i       one-cycle interrupt retire pulse
module miriscv_timer
  import miriscv_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_2000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        int_req_o,
  input  logic        int_fin_i
);

  // Window-relative address; BASE_ADDR is 32-byte aligned, so only [4:2] matter
  logic [31:0] win_addr;
  logic [2:0]  offs;
  assign win_addr = addr_i - BASE_ADDR;
  assign offs     = win_addr[4:2];

  logic wr_en, rd_en;
  assign wr_en = req_i && we_i;
  assign rd_en = req_i && !we_i;

  logic wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status;
  assign wr_ctrl   = wr_en && (offs == OFF_CTRL);
  assign wr_presc  = wr_en && (offs == OFF_PRESC);
  assign wr_cmp    = wr_en && (offs == OFF_CMP);
  assign wr_cnt    = wr_en && (offs == OFF_CNT);
  assign wr_status = wr_en && (offs == OFF_STATUS);

  logic [CTRL_W-1:0]  ctrl;
  logic [PRESC_W-1:0] presc;
  logic [31:0]        cmp;
  logic [31:0]        cnt;
  logic               pend;
  logic               tick;

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (ctrl[CTRL_EN]),
    .clr_i   (wr_ctrl || wr_presc),
    .presc_i (presc),
    .tick_o  (tick)
  );

  // A CNT write in a tick cycle suppresses both increment and match
  logic match;
  logic cnt_adv;
  assign cnt_adv = tick && !wr_cnt;
  assign match   = cnt_adv && (cnt == cmp);

  logic pend_clr;
  assign pend_clr = int_fin_i || (wr_status && be_i[0] && wdata_i[STATUS_PEND]);

  logic [31:0] presc_wr;
  assign presc_wr = merge_be(32'(presc), wdata_i, be_i);

  // Bits outside the decoded offset and above PRESC_W are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{win_addr[31:5], win_addr[1:0], presc_wr >> PRESC_W};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl  <= '0;
      presc <= '0;
      cmp   <= CMP_RESET;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      // Written EN takes priority over the one-shot stop
      if (wr_ctrl && be_i[0]) begin
        ctrl <= wdata_i[CTRL_W-1:0];
      end else if (match && !ctrl[CTRL_AUTO]) begin
        ctrl[CTRL_EN] <= 1'b0;
      end

      if (wr_presc) begin
        presc <= presc_wr[PRESC_W-1:0];
      end

      if (wr_cmp) begin
        cmp <= merge_be(cmp, wdata_i, be_i);
      end

      if (wr_cnt) begin
        cnt <= merge_be(cnt, wdata_i, be_i);
      end else if (cnt_adv) begin
        if (match) begin
          if (ctrl[CTRL_AUTO]) begin
            cnt <= '0;
          end
        end else begin
          cnt <= cnt + 32'd1;
        end
      end

      // A match in the same cycle as a retire keeps PEND set
      if (match) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

  assign int_req_o = pend && ctrl[CTRL_IRQ_EN];

  always_comb begin
    rdata_o = '0;
    if (rd_en) begin
      case (offs)
        OFF_CTRL:   rdata_o = 32'(ctrl);
        OFF_PRESC:  rdata_o = 32'(presc);
        OFF_CMP:    rdata_o = cmp;
        OFF_CNT:    rdata_o = cnt;
        OFF_STATUS: rdata_o = {30'd0, ctrl[CTRL_EN], pend};
        default:    rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_timer.sv
// tb_miriscv_timer
//   Randomised and directed bus traffic against miriscv_timer. The driver
//   keeps a behavioural model of the register map, queues the expected
//   rdata/int_req for every cycle, and a negedge monitor pops and compares.
module tb_miriscv_timer;

  localparam logic [31:0] BASE = 32'h8000_2000;
  localparam logic [2:0] O_CTRL = 3'd0, O_PRESC = 3'd1, O_CMP = 3'd2,
                         O_CNT = 3'd3, O_STATUS = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_req;
  logic        int_fin = 1'b0;

  always #5 clk = ~clk;

  miriscv_timer #(
    .BASE_ADDR (BASE),
    .PRESC_W   (16)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_i     (req),
    .we_i      (we),
    .be_i      (be),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .int_req_o (int_req),
    .int_fin_i (int_fin)
  );

  // Reference model state
  bit          m_en, m_auto, m_irq, m_pend;
  logic [15:0] m_presc;
  logic [31:0] m_cmp, m_cnt;
  int unsigned m_pcnt;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    logic [2:0]  off;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] b);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++)
      if (b[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      O_CTRL:   return {29'd0, m_irq, m_auto, m_en};
      O_PRESC:  return {16'd0, m_presc};
      O_CMP:    return m_cmp;
      O_CNT:    return m_cnt;
      O_STATUS: return {30'd0, m_en, m_pend};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irq = 0; m_pend = 0;
    m_presc = '0; m_cmp = 32'hFFFF_FFFF; m_cnt = '0; m_pcnt = 0;
  endtask

  // One bus cycle: drive, queue expected outputs, advance the model across the edge
  task automatic bus_cycle(input bit r, input bit w, input logic [3:0] b,
                           input logic [2:0] off, input logic [31:0] d, input bit fin);
    exp_t e;
    bit tick, cnt_wr, hit, wr;
    bit n_en, n_auto, n_irq, n_pend;
    logic [15:0] n_presc;
    logic [31:0] n_cmp, n_cnt, tmp;
    int unsigned n_pcnt;

    req = r; we = w; be = b; wdata = d; int_fin = fin;
    addr = BASE + {27'd0, off, 2'b00} + 32'($urandom_range(0, 3));

    e.rdata = (r && !w) ? model_read(off) : 32'd0;
    e.irq   = m_pend && m_irq;
    e.off   = off;
    sb.push_back(e);

    wr = r && w;
    n_en = m_en; n_auto = m_auto; n_irq = m_irq; n_pend = m_pend;
    n_presc = m_presc; n_cmp = m_cmp; n_cnt = m_cnt;

    tick   = m_en && (m_pcnt == 32'(m_presc));
    n_pcnt = (!m_en || tick) ? 0 : m_pcnt + 1;
    cnt_wr = wr && (off == O_CNT);
    hit    = tick && !cnt_wr && (m_cnt == m_cmp);
    if (tick && !cnt_wr) begin
      if (hit) begin
        if (m_auto) n_cnt = 32'd0;
        else        n_en  = 0;
      end else begin
        n_cnt = m_cnt + 32'd1;
      end
    end
    if (fin) n_pend = 0;
    if (wr) begin
      case (off)
        O_CTRL: begin
          if (b[0]) begin n_en = d[0]; n_auto = d[1]; n_irq = d[2]; end
          n_pcnt = 0;
        end
        O_PRESC: begin
          tmp = lanes({16'd0, m_presc}, d, b);
          n_presc = tmp[15:0];
          n_pcnt = 0;
        end
        O_CMP:    n_cmp = lanes(m_cmp, d, b);
        O_CNT:    n_cnt = lanes(m_cnt, d, b);
        O_STATUS: if (b[0] && d[0]) n_pend = 0;
        default: ;
      endcase
    end
    if (hit) n_pend = 1;

    @(posedge clk);
    #1;
    m_en = n_en; m_auto = n_auto; m_irq = n_irq; m_pend = n_pend;
    m_presc = n_presc; m_cmp = n_cmp; m_cnt = n_cnt; m_pcnt = n_pcnt;
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [31:0] d);
    bus_cycle(1, 1, 4'hF, off, d, 0);
  endtask

  task automatic rd_reg(input logic [2:0] off);
    bus_cycle(1, 0, 4'hF, off, 32'd0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(0, 0, 4'h0, 3'd0, 32'd0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle; int_req must drop immediately
  task automatic do_reset();
    req = 0; we = 0; int_fin = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_irq got=%b exp=0", int_req);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry per driven cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 2;
      if (rdata !== e.rdata) begin
        errors++;
        $display("FAIL rdata off=%0d got=%h exp=%h t=%0t", e.off, rdata, e.rdata, $time);
      end
      if (int_req !== e.irq) begin
        errors++;
        $display("FAIL int_req got=%b exp=%b t=%0t", int_req, e.irq, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [2:0]  off;
    logic [31:0] d;
    bit          fin;

    model_reset();
    #23 rst_n = 1;
    @(posedge clk);
    #1;

    // Randomised traffic with small values so matches and collisions occur
    for (int i = 0; i < 1500; i++) begin
      k   = $urandom_range(0, 7);
      off = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      d   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
      fin = ($urandom_range(0, 9) == 0);
      if (k < 2)      bus_cycle(1, 1, 4'($urandom_range(0, 15)), off, d, fin);
      else if (k < 6) bus_cycle(1, 0, 4'hF, off, 32'd0, fin);
      else            bus_cycle(0, 0, 4'h0, off, 32'd0, fin);
    end

    // Reset while the interrupt is asserted, then read back every offset
    wr_reg(O_PRESC, 0); wr_reg(O_CMP, 0); wr_reg(O_CNT, 0); wr_reg(O_CTRL, 32'h7);
    idle(3);
    do_reset();
    for (int i = 0; i < 8; i++) rd_reg(3'(i));

    // Byte-lane merge over CMP reset value
    bus_cycle(1, 1, 4'b0101, O_CMP, 32'hAABB_CCDD, 0);
    rd_reg(O_CMP);

    // Auto-reload with prescaler 3, match 24 cycles after CTRL write, then retire
    wr_reg(O_STATUS, 1); wr_reg(O_CMP, 5); wr_reg(O_PRESC, 3); wr_reg(O_CNT, 0);
    wr_reg(O_CTRL, 32'h7);
    repeat (26) rd_reg(O_STATUS);
    bus_cycle(1, 0, 4'hF, O_CNT, 32'd0, 1);
    rd_reg(O_STATUS);
    wr_reg(O_CTRL, 0);

    // One-shot
    wr_reg(O_STATUS, 1); wr_reg(O_CNT, 0); wr_reg(O_PRESC, 0); wr_reg(O_CMP, 2);
    wr_reg(O_CTRL, 32'h5);
    repeat (5) rd_reg(O_STATUS);
    rd_reg(O_CNT);
    wr_reg(O_STATUS, 1);
    rd_reg(O_STATUS);

    // Wrap: no flag when the counter rolls over
    wr_reg(O_CTRL, 0); wr_reg(O_STATUS, 1); wr_reg(O_CNT, 32'hFFFF_FFFE);
    wr_reg(O_CMP, 1); wr_reg(O_PRESC, 0); wr_reg(O_CTRL, 32'h1);
    rd_reg(O_CNT); rd_reg(O_CNT); rd_reg(O_STATUS);
    repeat (3) rd_reg(O_CNT);
    rd_reg(O_STATUS);

    // Collisions: retire during match, CNT write during tick
    wr_reg(O_CTRL, 0); wr_reg(O_STATUS, 1); wr_reg(O_PRESC, 0); wr_reg(O_CNT, 0);
    wr_reg(O_CMP, 3); wr_reg(O_CTRL, 32'h7);
    idle(3);
    bus_cycle(1, 0, 4'hF, O_STATUS, 32'd0, 1);
    rd_reg(O_STATUS);
    wr_reg(O_CNT, 7);
    rd_reg(O_CNT);
    wr_reg(O_CTRL, 0);
    idle(2);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
